// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR decimator.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    localparam int NUM_DEFAULT_COEF = 16;

    // Symmetric Hamming-windowed low-pass; coefficients sum to 30348.
    localparam int DEFAULT_COEF [NUM_DEFAULT_COEF] = '{
        173, 288, 548, 1001, 1691, 2633, 3787, 5053,
        5053, 3787, 2633, 1691, 1001, 548, 288, 173
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_delay_ram.sv
// Per-channel circular sample history for the FIR MAC.
// Latency: one-cycle registered read; write lands on the clock edge.
// Backpressure: none, both ports are always available.
module fir_delay_ram #(
    parameter int NUM_CH = 1,
    parameter int TAPS   = 16,
    parameter int DATA_W = 16,
    parameter int CH_W   = 1,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [ADDR_W-1:0]        wr_ptr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [NUM_CH][TAPS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mem[c][t] <= '0;
                end
            end
            rd_data <= '0;
        end else begin
            if (wr_en) mem[wr_ch][wr_ptr] <= wr_data;
            rd_data <= mem[rd_ch][rd_addr];
        end
    end

endmodule

// File: rtl/fir_mac_decim.sv
// Multi-channel serial-MAC FIR low-pass decimator with run-time coefficients.
// Latency: TAPS+2 cycles from the triggering accept to the out_valid strobe.
// Backpressure: in_ready low while a computation runs; output is never stalled.
module fir_mac_decim
    import fir_pkg::*;
#(
    parameter int TAPS      = 16,
    parameter int NUM_CH    = 1,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int DECIM     = 1,
    parameter int OUT_SHIFT = 17,
    localparam int CH_W     = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1,
    localparam int ADDR_W   = clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat
);

    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int TAP_W  = clog2(TAPS + 1);
    localparam int PH_W   = (clog2(DECIM) > 0) ? clog2(DECIM) : 1;

    localparam logic signed [ACC_W:0] RND_K  = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    fir_state_t state_q, state_d;

    logic [ADDR_W-1:0]        wr_ptr_q [NUM_CH];
    logic [PH_W-1:0]          ph_q     [NUM_CH];
    logic signed [COEF_W-1:0] coef_q   [TAPS];
    logic [ADDR_W-1:0]        base_q;
    logic [CH_W-1:0]          mac_ch_q;
    logic [TAP_W-1:0]         tap_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic                     idle, accept, ch_ok, wr_en, trig;
    logic [ADDR_W-1:0]        rd_addr, coef_idx;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W:0]    rnd, shifted;
    logic signed [DATA_W-1:0] sat_data;
    logic                     sat_flag;

    assign idle     = (state_q == IDLE);
    assign in_ready = idle;
    assign accept   = in_valid && idle;
    // Out-of-range channel tags complete the handshake but touch nothing.
    assign ch_ok    = int'(in_ch) < NUM_CH;
    assign wr_en    = accept && ch_ok;
    assign trig     = wr_en && (ph_q[in_ch] == PH_W'(DECIM - 1));

    fir_delay_ram #(
        .NUM_CH (NUM_CH),
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ch   (in_ch),
        .wr_ptr  (wr_ptr_q[in_ch]),
        .wr_data (in_data),
        .rd_ch   (mac_ch_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Read runs one tap ahead of the multiply: tap k reads x[n-k], product uses coef[k] a cycle later.
    always_comb begin
        if (TAP_W'(base_q) >= tap_q) rd_addr = ADDR_W'(TAP_W'(base_q) - tap_q);
        else                         rd_addr = ADDR_W'(TAP_W'(base_q) + (TAP_W'(TAPS) - tap_q));
        coef_idx = (tap_q == '0) ? '0 : ADDR_W'(tap_q - TAP_W'(1));
    end

    always_comb begin
        prod     = PROD_W'(rd_data) * PROD_W'(coef_q[coef_idx]);
        acc_next = acc_q + ACC_W'(prod);
        rnd      = (ACC_W + 1)'(acc_next) + RND_K;
        shifted  = rnd >>> OUT_SHIFT;
        sat_flag = 1'b0;
        sat_data = shifted[DATA_W-1:0];
        if (shifted > SAT_HI) begin
            sat_data = {1'b0, {(DATA_W - 1){1'b1}}};
            sat_flag = 1'b1;
        end else if (shifted < SAT_LO) begin
            sat_data = {1'b1, {(DATA_W - 1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    if (trig) state_d = MAC;
            MAC:     if (tap_q == TAP_W'(TAPS)) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                ph_q[c]     <= '0;
            end
            for (int k = 0; k < TAPS; k++) begin
                if (k < NUM_DEFAULT_COEF) coef_q[k] <= COEF_W'(DEFAULT_COEF[k]);
                else                      coef_q[k] <= '0;
            end
            base_q   <= '0;
            mac_ch_q <= '0;
            tap_q    <= '0;
            acc_q    <= '0;
            out_ch   <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (coef_we && idle && (int'(coef_addr) < TAPS)) coef_q[coef_addr] <= coef_data;
            if (wr_en) begin
                wr_ptr_q[in_ch] <= (wr_ptr_q[in_ch] == ADDR_W'(TAPS - 1)) ? '0 : wr_ptr_q[in_ch] + ADDR_W'(1);
                ph_q[in_ch]     <= trig ? '0 : ph_q[in_ch] + PH_W'(1);
            end
            if (trig) begin
                base_q   <= wr_ptr_q[in_ch];
                mac_ch_q <= in_ch;
                tap_q    <= '0;
                acc_q    <= '0;
            end
            if (state_q == MAC) begin
                tap_q <= tap_q + TAP_W'(1);
                if (tap_q != '0) acc_q <= acc_next;
                // The last product folds straight into the output register so it is ready in DONE.
                if (tap_q == TAP_W'(TAPS)) begin
                    out_ch   <= mac_ch_q;
                    out_data <= sat_data;
                    out_sat  <= sat_flag;
                end
            end
        end
    end

endmodule
